// File: rtl/map_gen_core.sv
// map_gen_core: scrolling 16-column obstacle-map generator for the endless runner.
// The map shifts one column toward the player (bit MAP_W-1) on each game tick.
// The new bit 0 comes from a 16-bit LFSR, gated by a difficulty-dependent density
// threshold and a minimum-spacing counter.
// The game tick is the rising edge of clk_div. clk_div is synchronised into
// clk_sys through a three-stage register chain and treated as data.
// Optional build macro: JUMP_ENTROPY_EN. When defined, the player jump level is
// mixed into the LFSR feedback. When undefined, jump is ignored and the map is
// fully deterministic.
module map_gen_core #(
  parameter int          MAP_W     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             clk_div,
  input  logic             en,
  input  logic             jump,
  input  logic [1:0]       difficulty,
  output logic [MAP_W-1:0] map
);

  // synchroniser / edge-detect chain for the slow tick level
  logic s1_q, s2_q, s3_q;
  logic tick;

  // generator state
  logic [15:0]      lfsr_q, lfsr_d;
  logic [3:0]       gap_q, gap_d;
  logic [MAP_W-1:0] map_q, map_d;

  // combinational helpers
  logic [3:0]  thr;
  logic [3:0]  min_gap;
  logic        fb;
  logic [15:0] lfsr_shift;
  logic        new_bit;

`ifndef JUMP_ENTROPY_EN
  // jump only matters when entropy mixing is built in
  logic unused_jump;
  assign unused_jump = jump;
`endif

  // one tick per clk_div rising edge, seen two clk_sys edges after the rise
  assign tick = s2_q & ~s3_q;

  // difficulty -> obstacle density threshold and minimum zero run between obstacles
  always_comb begin
    thr     = 4'd2;
    min_gap = 4'd5;
    case (difficulty)
      2'd0: begin thr = 4'd2; min_gap = 4'd5; end
      2'd1: begin thr = 4'd4; min_gap = 4'd4; end
      2'd2: begin thr = 4'd6; min_gap = 4'd3; end
      2'd3: begin thr = 4'd8; min_gap = 4'd2; end
      default: begin thr = 4'd2; min_gap = 4'd5; end
    endcase
  end

  // next-state: LFSR advances every enabled cycle, map/gap only on an enabled tick
  always_comb begin
    // taps x^16 + x^14 + x^13 + x^11 -> bits 15, 13, 12, 10
`ifdef JUMP_ENTROPY_EN
    fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10] ^ jump;
`else
    fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
`endif
    lfsr_shift = {lfsr_q[14:0], fb};

    lfsr_d = lfsr_q;
    if (en) begin
      // never let the register lock up in the all-zero state
      lfsr_d = (lfsr_shift == 16'h0000) ? LFSR_SEED : lfsr_shift;
    end

    // decision uses the LFSR value present on the tick cycle, before it advances
    new_bit = (lfsr_q[3:0] < thr) && (gap_q >= min_gap);

    map_d = map_q;
    gap_d = gap_q;
    if (en && tick) begin
      map_d = {map_q[MAP_W-2:0], new_bit};
      if (new_bit) begin
        gap_d = 4'd0;
      end else if (gap_q != 4'hF) begin
        gap_d = gap_q + 4'd1;
      end
    end
  end

  // state registers with asynchronous clear; sync chain tracks clk_div even when frozen
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      lfsr_q <= LFSR_SEED;
      gap_q  <= 4'd0;
      map_q  <= '0;
    end else begin
      s1_q   <= clk_div;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      lfsr_q <= lfsr_d;
      gap_q  <= gap_d;
      map_q  <= map_d;
    end
  end

  assign map = map_q;

endmodule

// File: tb/tb_map_gen_core.sv
// Testbench for map_gen_core (default build, jump ignored).
// A behavioural reference model predicts the map for every clk_sys edge.
// Each prediction is queued when the inputs for that cycle are applied, then
// popped and compared one time unit after the edge.
module tb_map_gen_core;

  logic        clk_sys = 1'b0;
  logic        rst_n   = 1'b1;
  logic        clk_div = 1'b0;
  logic        en      = 1'b0;
  logic        jump    = 1'b0;
  logic [1:0]  difficulty = 2'd0;
  logic [15:0] map;

  always #5 clk_sys = ~clk_sys;

  map_gen_core #(.MAP_W(16), .LFSR_SEED(16'hACE1)) dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .clk_div    (clk_div),
    .en         (en),
    .jump       (jump),
    .difficulty (difficulty),
    .map        (map)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] exp_q[$];

  // reference model state
  logic        m_s1, m_s2, m_s3;
  logic [15:0] m_lfsr;
  logic [15:0] m_map;
  int          m_gap;

  // spacing / density statistics observed on the DUT output
  int ones_cnt;
  int zeros_since;
  int min_zeros;

  logic [15:0] seq_a[6];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_s1 = 1'b0; m_s2 = 1'b0; m_s3 = 1'b0;
    m_lfsr = 16'hACE1;
    m_map  = 16'h0000;
    m_gap  = 0;
  endtask

  task automatic stats_reset();
    ones_cnt = 0; zeros_since = 99; min_zeros = 99;
  endtask

  // one clk_sys cycle: predict, push, wait for the edge, pop and compare
  task automatic cyc();
    logic        tk;
    logic        nb;
    logic [15:0] nl;
    logic [15:0] exp;
    int          thr_v, mg_v;
    bit          ins;
    ins = 1'b0;
    nb  = 1'b0;
    if (rst_n) begin
      tk    = m_s2 && !m_s3;
      thr_v = 2 * (int'(difficulty) + 1);
      mg_v  = 5 - int'(difficulty);
      if (en && tk) begin
        nb    = (int'(m_lfsr[3:0]) < thr_v) && (m_gap >= mg_v);
        m_map = {m_map[14:0], nb};
        m_gap = nb ? 0 : ((m_gap < 15) ? m_gap + 1 : 15);
        ins   = 1'b1;
      end
      if (en) begin
        nl     = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
        m_lfsr = (nl == 16'h0000) ? 16'hACE1 : nl;
      end
      m_s3 = m_s2;
      m_s2 = m_s1;
      m_s1 = clk_div;
    end
    exp_q.push_back(m_map);
    @(posedge clk_sys);
    #1;
    exp = exp_q.pop_front();
    check_eq("map", 32'(map), 32'(exp));
    if (ins) begin
      if (map[0]) begin
        ones_cnt++;
        if (zeros_since < min_zeros) min_zeros = zeros_since;
        zeros_since = 0;
      end else begin
        zeros_since++;
      end
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    clk_div = 1'b1;
    repeat (hi) cyc();
    clk_div = 1'b0;
    repeat (lo) cyc();
  endtask

  // six difficulty-0 ticks straight after a clean start; replay compares against the first run
  task automatic run_seq(input bit replay);
    en = 1'b1;
    difficulty = 2'd0;
    for (int i = 0; i < 6; i++) begin
      pulse(4, 4);
      if (!replay) begin
        seq_a[i] = m_map;
        if (i < 5) check_eq("t2_zero", 32'(map), 32'h0);
        $display("t2 tick %0d map=%04h", i + 1, map);
      end else begin
        check_eq("t5_replay", 32'(map), 32'(seq_a[i]));
        $display("t5 replay tick %0d map=%04h", i + 1, map);
      end
    end
  endtask

  initial begin
    logic [15:0] saved;
    int ones3, ones0, min3, min0, tries;
    stats_reset();
    model_reset();

    // test 1: async reset, then idle ticks with en=0
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_eq("rst_async", 32'(map), 32'h0);
    repeat (3) cyc();
    rst_n = 1'b1;
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pulse(4, 4);
      check_eq("t1_idle", 32'(map), 32'h0);
      $display("t1 tick %0d map=%04h", i + 1, map);
    end

    // test 2: first min_gap ticks at easy difficulty insert nothing
    run_seq(1'b0);

    // test 3: tick latency, rise right after edge t
    difficulty = 2'd2;
    saved = m_map;
    clk_div = 1'b1;
    cyc();
    check_eq("t3_hold1", 32'(map), 32'(saved));
    cyc();
    check_eq("t3_hold2", 32'(map), 32'(saved));
    cyc();
    check_eq("t3_shift", 32'(map[15:1]), 32'(saved[14:0]));
    $display("t3 shift map=%04h", map);
    cyc();
    clk_div = 1'b0;
    repeat (4) cyc();

    // test 4: spacing and density at hard vs easy
    difficulty = 2'd3;
    stats_reset();
    repeat (500) pulse(4, 4);
    ones3 = ones_cnt; min3 = min_zeros;
    $display("t4 difficulty=3 ones=%0d min_zeros=%0d", ones3, min3);
    check_eq("t4_gap3", 32'(min3 >= 2), 32'h1);
    difficulty = 2'd0;
    stats_reset();
    repeat (500) pulse(4, 4);
    ones0 = ones_cnt; min0 = min_zeros;
    $display("t4 difficulty=0 ones=%0d min_zeros=%0d", ones0, min0);
    check_eq("t4_gap0", 32'(min0 >= 5), 32'h1);
    check_eq("t4_density", 32'(ones0 < ones3), 32'h1);

    // test 5: async reset mid-tick with a nonzero map, then replay of test 2
    difficulty = 2'd3;
    tries = 0;
    while (m_map == 16'h0000 && tries < 200) begin
      pulse(4, 4);
      tries++;
    end
    if (m_map == 16'h0000) check_eq("t5_nz_timeout", 32'h0, 32'h1);
    check_eq("t5_pre_nz", 32'(map != 16'h0000), 32'h1);
    clk_div = 1'b1;
    cyc();
    cyc();
    @(negedge clk_sys);
    rst_n = 1'b0;
    model_reset();
    #1 check_eq("t5_rst_now", 32'(map), 32'h0);
    $display("t5 reset map=%04h", map);
    repeat (2) cyc();
    clk_div = 1'b0;
    repeat (4) cyc();
    rst_n = 1'b1;
    en = 1'b0;
    repeat (4) cyc();
    run_seq(1'b1);

    // test 6: freeze for three ticks, then resume with no catch-up
    difficulty = 2'd3;
    repeat (10) pulse(4, 4);
    saved = m_map;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pulse(4, 4);
      check_eq("t6_frozen", 32'(map), 32'(saved));
      $display("t6 frozen tick %0d map=%04h", i + 1, map);
    end
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      pulse(4, 4);
      $display("t6 resume tick %0d map=%04h", i + 1, map);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
